// File: rtl/noc_packetizer_pkg.sv
// Shared flit format, routing-header field offsets and packetizer state encoding.
// Routers decode headers with the same offset helpers.
package noc_packetizer_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_DEST_W = 4;
    localparam int unsigned AXI_USER_W = 4;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned CNT_W      = 16;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] tdata;
        logic [AXI_ID_W-1:0]   tid;
        logic [AXI_DEST_W-1:0] tdest;
        logic [AXI_USER_W-1:0] tuser;
    } axi_packet_t;

    localparam logic [AXI_ID_W-1:0] ROUTING_HEADER = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } packetizer_state_t;

    // Header TDATA layout for coordinate width w: {len, src_x, src_y, dst_x, dst_y}
    localparam int unsigned Y_LSB = 0;

    function automatic int unsigned x_lsb(input int unsigned w);
        return w;
    endfunction

    function automatic int unsigned src_y_lsb(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned src_x_lsb(input int unsigned w);
        return 3 * w;
    endfunction

    function automatic int unsigned len_lsb(input int unsigned w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/noc_flit_reg.sv
// One-entry valid/ready output register; loads only when empty or being drained.
module noc_flit_reg
    import noc_packetizer_pkg::*;
#(
    parameter type flit_t = axi_packet_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  flit_t i_data,
    input  logic  i_ready,
    output flit_t o_data,
    output logic  o_valid,
    output logic  o_free_c
);

    flit_t r_data;
    logic  r_valid;
    logic  w_free;

    assign w_free   = !r_valid || i_ready;
    assign o_free_c = w_free;
    assign o_data   = r_data;
    assign o_valid  = r_valid;

    // Hold contents while stalled; an idle free slot drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_free) begin
            r_valid <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Injection-side packetizer: one routing header flit followed by len body flits,
// all through a single registered valid/ready output stage.
module noc_packetizer
    import noc_packetizer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned ID_WIDTH            = 4,
    parameter int unsigned DEST_WIDTH          = 4,
    parameter int unsigned USER_WIDTH          = 4,
    parameter int unsigned MAX_ROUTERS_X       = 4,
    parameter int unsigned MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
    parameter int unsigned MAX_ROUTERS_Y       = 4,
    parameter int unsigned MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
    parameter int unsigned LOCAL_X             = 0,
    parameter int unsigned LOCAL_Y             = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] req_target_x,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] req_target_y,
    input  logic [LEN_W-1:0]               req_len,
    input  logic [ID_WIDTH-1:0]            req_id,
    input  axi_packet_t                    in,
    input  logic                           in_valid,
    output logic                           in_ready,
    output axi_packet_t                    out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           len_err,
    output logic [CNT_W-1:0]               pkt_count
);

    localparam int unsigned W         = MAX_ROUTERS_X_WIDTH;
    localparam int unsigned X_LSB     = x_lsb(W);
    localparam int unsigned SRC_Y_LSB = src_y_lsb(W);
    localparam int unsigned SRC_X_LSB = src_x_lsb(W);
    localparam int unsigned LEN_LSB   = len_lsb(W);
    localparam logic [W-1:0] L_X      = W'(LOCAL_X);
    localparam logic [W-1:0] L_Y      = W'(LOCAL_Y);

    if (MAX_ROUTERS_X_WIDTH != MAX_ROUTERS_Y_WIDTH) begin : g_err_xy_width
        $error("noc_packetizer: x and y coordinate widths must match");
    end
    if (DATA_WIDTH != AXI_DATA_W || ID_WIDTH != AXI_ID_W ||
        DEST_WIDTH != AXI_DEST_W || USER_WIDTH != AXI_USER_W) begin : g_err_axi
        $error("noc_packetizer: AXI widths must match axi_packet_t");
    end
    if (DATA_WIDTH < 4 * W + LEN_W) begin : g_err_data_width
        $error("noc_packetizer: DATA_WIDTH too small for routing header");
    end
    if (LOCAL_X >= MAX_ROUTERS_X || LOCAL_Y >= MAX_ROUTERS_Y) begin : g_err_local
        $error("noc_packetizer: local coordinates outside mesh");
    end

    packetizer_state_t r_state;
    packetizer_state_t w_next_state;
    logic [LEN_W-1:0]    r_remaining;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_len_err;
    logic [CNT_W-1:0]    r_pkt_count;

    logic        w_free;
    logic        w_load;
    logic        w_req_ready;
    logic        w_in_ready;
    logic        w_hdr_fire;
    logic        w_zero_fire;
    logic        w_body_fire;
    axi_packet_t w_hdr;
    axi_packet_t w_body;
    axi_packet_t w_flit;

    // Header built straight from the request so it can load in the fire cycle.
    always_comb begin
        w_hdr                           = '0;
        w_hdr.tid                       = ROUTING_HEADER;
        w_hdr.tdata[Y_LSB +: W]         = req_target_y;
        w_hdr.tdata[X_LSB +: W]         = req_target_x;
        w_hdr.tdata[SRC_Y_LSB +: W]     = L_Y;
        w_hdr.tdata[SRC_X_LSB +: W]     = L_X;
        w_hdr.tdata[LEN_LSB +: LEN_W]   = req_len;
        w_body                          = in;
        w_body.tid                      = r_id;
    end

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_flit       = w_hdr;
        w_hdr_fire   = 1'b0;
        w_zero_fire  = 1'b0;
        w_body_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = w_free;
                if (req_valid && w_free) begin
                    if (req_len != '0) begin
                        w_load       = 1'b1;
                        w_hdr_fire   = 1'b1;
                        w_next_state = BODY;
                    end else begin
                        w_zero_fire = 1'b1;
                    end
                end
            end
            BODY: begin
                w_in_ready = w_free;
                w_flit     = w_body;
                if (in_valid && w_free) begin
                    w_load      = 1'b1;
                    w_body_fire = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_id        <= '0;
            r_len_err   <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_len_err <= w_zero_fire;
            if (w_hdr_fire) begin
                r_remaining <= req_len;
                r_id        <= req_id;
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end else if (w_body_fire) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    noc_flit_reg #(
        .flit_t (axi_packet_t)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_flit),
        .i_ready  (out_ready),
        .o_data   (out),
        .o_valid  (out_valid),
        .o_free_c (w_free)
    );

    assign req_ready = w_req_ready;
    assign in_ready  = w_in_ready;
    assign busy      = (r_state == BODY) || out_valid;
    assign len_err   = r_len_err;
    assign pkt_count = r_pkt_count;

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Injection-side transmitter for the router's packet-switched AXI-Stream flit channel.
- Takes a packet request (target router, body length, ID) plus a stream of payload words.
- Emits one ROUTING_HEADER flit, then exactly `len` body flits, through a single registered output stage. This is the format that router input arbiters lock onto for a whole packet.
- Sits between a network interface (AXI master/slave adapter) and a router local port.

Parameters:
- DATA_WIDTH, 32, TDATA width; must be >= 2*(MAX_ROUTERS_X_WIDTH+MAX_ROUTERS_Y_WIDTH)+8.
- ID_WIDTH, 4, TID width.
- DEST_WIDTH, 4, TDEST width.
- USER_WIDTH, 4, TUSER width.
- MAX_ROUTERS_X, 4, mesh columns.
- MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), x coordinate width.
- MAX_ROUTERS_Y, 4, mesh rows.
- MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), y coordinate width; must equal MAX_ROUTERS_X_WIDTH (elaboration assertion).
- LOCAL_X, 0, this node's x coordinate.
- LOCAL_Y, 0, this node's y coordinate.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  packet request valid.
- req_ready  output  1  request accepted.
- req_target_x  input  MAX_ROUTERS_X_WIDTH  destination x.
- req_target_y  input  MAX_ROUTERS_Y_WIDTH  destination y.
- req_len  input  8  body flit count.
- req_id  input  ID_WIDTH  TID for body flits.
- in  input  axi_packet_t  payload word.
- in_valid  input  1  payload valid.
- in_ready  output  1  payload accepted.
- out  output  axi_packet_t  flit to router.
- out_valid  output  1  flit valid.
- out_ready  input  1  router accepts flit.
- busy  output  1  state==BODY or out_valid.
- len_err  output  1  one-cycle pulse on a zero-length request.
- pkt_count  output  16  headers emitted, wraps at 2^16.

Behaviour:
- Reset values (asserted asynchronously): state IDLE, remaining 0, out_valid 0, out 0, len_err 0, pkt_count 0, busy 0.
- A reset asserted mid-packet drops the packet; no partial flits appear after release.

Output stage:
- One register; out and out_valid are held stable while out_valid && !out_ready.
- free = !out_valid || out_ready. The register loads only when free.
- If free and nothing loads, out_valid clears next cycle.

State machine:
- IDLE:
  - req_ready = free.
  - On req fire with req_len != 0: latch target, len and id into regs; set remaining = req_len; load header into the output register; go to BODY; increment pkt_count.
  - On req fire with req_len == 0: request consumed, len_err = 1 next cycle, stay IDLE, no flit.
  - in_ready = 0.
- BODY:
  - req_ready = 0; in_ready = free.
  - On in fire: output register takes `in` with TID replaced by the latched id; all other fields pass through; remaining decrements.
  - If remaining == 1 at fire, go to IDLE.

Header flit:
- TID = ROUTING_HEADER; TDEST = 0; TUSER = 0.
- TDATA layout, W = MAX_ROUTERS_X_WIDTH:
  - [W-1:0] = target_y
  - [2W-1:W] = target_x
  - [3W-1:2W] = LOCAL_Y
  - [4W-1:3W] = LOCAL_X
  - [4W+7:4W] = len
  - upper bits 0.
- len counts body flits only; the header is excluded.

Latency and throughput:
- Header appears on out the cycle after req fire.
- Each body flit appears the cycle after its in fire.
- Back-to-back packets with out_ready=1 sustain one flit per cycle, with no bubble between a last body flit and the next header.

Boundary conditions:
- len = 255: the 8-bit remaining counter never wraps.
- Simultaneous last-body fire and new req: impossible, because req_ready = 0 in BODY.
- A payload TID equal to ROUTING_HEADER is harmless, since TID is overwritten.

Decomposition:
- Shared package / axi_type.svh:
  - axi_packet_t
  - ROUTING_HEADER
  - header field offset constants (Y_LSB, X_LSB, SRC_Y_LSB, SRC_X_LSB, LEN_LSB as functions of W)
  - state enum packetizer_state_t {IDLE, BODY}.
- Routers use the same offset constants for decode.
- Optional sub-module noc_flit_reg: a one-entry valid/ready output register, reusable for router output stages.

Test Plan:
- LOCAL_X=1, LOCAL_Y=2, W=2; req (x=3, y=0, len=3, id=5), body 0xA, 0xB, 0xC, out_ready=1 -> four consecutive flits:
  - header TDATA=0x36C, TID=ROUTING_HEADER;
  - body TDATA 0xA/0xB/0xC, each TID=5;
  - pkt_count=1.
- Same packet with out_ready=0 for 5 cycles after the header appears -> out held at 0x36C, in_ready=0 throughout; completes after ready returns; no flit lost or duplicated.
- Two back-to-back requests, len=1 each, ready=1 -> header, body, header, body on 4 consecutive cycles; pkt_count=2.
- req_len=0 -> len_err high exactly 1 cycle, out_valid stays 0, req_ready high again the next cycle.
- len=4, rst pulsed after the 1st body flit -> out_valid=0 immediately; after release, state IDLE, req_ready=1, pkt_count=0; a new len=1 packet emits correctly.
- len=255 with random in_valid/out_ready -> exactly 256 flits, header len field 0xFF, busy falls after the last handshake.
